three_output_demux: RTL and testbench

THREE_OUTPUT_DEMUX -- requirements
Module: three_output_demux

---
 rtl/three_output_demux.sv | 92 +++++++++
 tb/tb_three_output_demux.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/three_output_demux.sv
// Routes one input word per cycle to one of three single-entry output channels.
// A select of 11 drops the word and records it in a sticky flag and a saturating counter.
//
// state | meaning
// EMPTY | channel holds no word; out_valid[i] low
// FULL  | channel holds a word awaiting its consumer; out_valid[i] high
module three_output_demux #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            select,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [2:0]            out_valid,
    input  logic [2:0]            out_ready,
    output logic [DATA_WIDTH-1:0] out00,
    output logic [DATA_WIDTH-1:0] out01,
    output logic [DATA_WIDTH-1:0] out10,
    output logic                  illegal_sel,
    output logic [7:0]            drop_count
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_t;

    chan_state_t           state_q [3];
    chan_state_t           state_d [3];
    logic [DATA_WIDTH-1:0] data_q  [3];
    logic [2:0]            full;
    logic [2:0]            load;
    logic                  accept;
    logic                  sel_legal;

    assign sel_legal = (select != 2'b11);
    assign accept    = in_valid && in_ready;
    assign out_valid = full;
    assign out00     = data_q[0];
    assign out01     = data_q[1];
    assign out10     = data_q[2];

    // A FULL channel can still take a word if its consumer drains it on the same edge.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (select)
                2'b00:   in_ready = !full[0] || out_ready[0];
                2'b01:   in_ready = !full[1] || out_ready[1];
                2'b10:   in_ready = !full[2] || out_ready[2];
                default: in_ready = 1'b1;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            full[i]    = (state_q[i] == FULL);
            load[i]    = accept && sel_legal && (select == 2'(i));
            state_d[i] = state_q[i];
            if (load[i]) begin
                state_d[i] = FULL;
            end else if (full[i] && out_ready[i]) begin
                state_d[i] = EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= EMPTY;
                data_q[i]  <= '0;
            end
            illegal_sel <= 1'b0;
            drop_count  <= 8'd0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                if (load[i]) begin
                    data_q[i] <= in_data;
                end
            end
            if (accept && !sel_legal) begin
                illegal_sel <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_three_output_demux.sv
// Directed bench for three_output_demux: each task drives one scenario and checks
// hand-computed expectations inline.
module tb_three_output_demux;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    select;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [2:0]    out_valid;
    logic [2:0]    out_ready;
    logic [DW-1:0] out00;
    logic [DW-1:0] out01;
    logic [DW-1:0] out10;
    logic          illegal_sel;
    logic [7:0]    drop_count;

    int checks = 0;
    int errors = 0;

    three_output_demux #(.DATA_WIDTH(DW)) dut (
        .clk(clk),
        .rst(rst),
        .select(select),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out00(out00),
        .out01(out01),
        .out10(out10),
        .illegal_sel(illegal_sel),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; select = 2'b00; in_data = 32'hFFFF_FFFF; out_ready = 3'b111;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        step();
        step();
        checks++;
        if (out_valid !== 3'b000) begin errors++; $display("FAIL reset_out_valid: got %b expected 000", out_valid); end
        checks++;
        if (out00 !== 0 || out01 !== 0 || out10 !== 0) begin
            errors++; $display("FAIL reset_data: got %h %h %h expected 0 0 0", out00, out01, out10);
        end
        checks++;
        if (illegal_sel !== 1'b0 || drop_count !== 8'd0) begin
            errors++; $display("FAIL reset_flags: got %b %0d expected 0 0", illegal_sel, drop_count);
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 3'b000;
        #1;
    endtask

    task automatic test_route();
        select = 2'b01; in_data = 32'hDEAD_BEEF; in_valid = 1'b1; out_ready = 3'b000;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL route_in_ready: got %b expected 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 3'b010) begin errors++; $display("FAIL route_out_valid: got %b expected 010", out_valid); end
        checks++;
        if (out01 !== 32'hDEAD_BEEF || out00 !== 0 || out10 !== 0) begin
            errors++; $display("FAIL route_data: got %h %h %h expected 0 deadbeef 0", out00, out01, out10);
        end
        out_ready = 3'b010;
        step();
        out_ready = 3'b000;
        checks++;
        if (out_valid !== 3'b000 || out01 !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL route_pop_hold: got %b %h expected 000 deadbeef", out_valid, out01);
        end
    endtask

    task automatic test_backpressure();
        select = 2'b00; in_data = 32'h11; in_valid = 1'b1; out_ready = 3'b000;
        step();
        in_data = 32'h22;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready: got %b expected 0", in_ready); end
        step();
        checks++;
        if (out00 !== 32'h11 || out_valid !== 3'b001) begin
            errors++; $display("FAIL bp_hold: got %h %b expected 11 001", out00, out_valid);
        end
        out_ready = 3'b001;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        step();
        in_valid = 1'b0; out_ready = 3'b000;
        checks++;
        if (out00 !== 32'h22 || out_valid !== 3'b001) begin
            errors++; $display("FAIL bp_pop_load: got %h %b expected 22 001", out00, out_valid);
        end
    endtask

    task automatic test_independence();
        select = 2'b10; in_data = 32'h33; in_valid = 1'b1; out_ready = 3'b000;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL indep_ready: got %b expected 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 3'b101 || out10 !== 32'h33 || out00 !== 32'h22) begin
            errors++; $display("FAIL indep_state: got %b %h %h expected 101 33 22", out_valid, out10, out00);
        end
    endtask

    task automatic test_illegal();
        select = 2'b11; in_data = 32'hBAD0_BAD0; in_valid = 1'b1; out_ready = 3'b000;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready: got %b expected 1", in_ready); end
        for (int k = 0; k < 3; k++) step();
        checks++;
        if (illegal_sel !== 1'b1 || drop_count !== 8'd3) begin
            errors++; $display("FAIL illegal_three: got %b %0d expected 1 3", illegal_sel, drop_count);
        end
        checks++;
        if (out_valid !== 3'b101 || out00 !== 32'h22 || out01 !== 32'hDEAD_BEEF || out10 !== 32'h33) begin
            errors++; $display("FAIL illegal_no_write: got %b %h %h %h expected 101 22 deadbeef 33",
                               out_valid, out00, out01, out10);
        end
        for (int k = 3; k < 255; k++) step();
        checks++;
        if (drop_count !== 8'd255) begin errors++; $display("FAIL illegal_at_255: got %0d expected 255", drop_count); end
        for (int k = 255; k < 300; k++) step();
        in_valid = 1'b0;
        checks++;
        if (drop_count !== 8'd255 || illegal_sel !== 1'b1) begin
            errors++; $display("FAIL illegal_saturate: got %0d %b expected 255 1", drop_count, illegal_sel);
        end
        step();
        checks++;
        if (drop_count !== 8'd255 || illegal_sel !== 1'b1) begin
            errors++; $display("FAIL illegal_idle_hold: got %0d %b expected 255 1", drop_count, illegal_sel);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 3'b111; in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 3'b000) begin errors++; $display("FAIL b2b_drain: got %b expected 000", out_valid); end
        out_ready = 3'b010; select = 2'b01; in_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_data = DW'(k);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b expected 1", k, in_ready); end
            step();
            checks++;
            if (out_valid !== 3'b010 || out01 !== DW'(k)) begin
                errors++; $display("FAIL b2b_word_%0d: got %b %h expected 010 %h", k, out_valid, out01, k);
            end
        end
        in_valid = 1'b0;
        step();
        out_ready = 3'b000;
        checks++;
        if (out_valid !== 3'b000 || out01 !== 32'h8) begin
            errors++; $display("FAIL b2b_final: got %b %h expected 000 8", out_valid, out01);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; out_ready = 3'b000;
        select = 2'b00; in_data = 32'hA; step();
        select = 2'b01; in_data = 32'hB; step();
        select = 2'b10; in_data = 32'hC; step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 3'b111 || out00 !== 32'hA || out01 !== 32'hB || out10 !== 32'hC) begin
            errors++; $display("FAIL mid_fill: got %b %h %h %h expected 111 a b c", out_valid, out00, out01, out10);
        end
        rst = 1'b1; in_valid = 1'b1; select = 2'b00; in_data = 32'h55; out_ready = 3'b111;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b expected 0", in_ready); end
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 3'b000;
        #1;
        checks++;
        if (out_valid !== 3'b000 || out00 !== 0 || out01 !== 0 || out10 !== 0) begin
            errors++; $display("FAIL mid_rst_chan: got %b %h %h %h expected 000 0 0 0", out_valid, out00, out01, out10);
        end
        checks++;
        if (illegal_sel !== 1'b0 || drop_count !== 8'd0) begin
            errors++; $display("FAIL mid_rst_flags: got %b %0d expected 0 0", illegal_sel, drop_count);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_post_ready: got %b expected 1", in_ready); end
    endtask

    initial begin
        rst = 1'b1; select = 2'b00; in_valid = 1'b0; in_data = '0; out_ready = 3'b000;
        test_reset();
        test_route();
        test_backpressure();
        test_independence();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
